skid_fill: RTL



---
 rtl/skid_fill.sv | 113 +++++++++++
 1 files changed

// File: rtl/skid_fill.sv
// skid_fill: write-side adapter from an upstream valid/ready stream to a
// synchronous FIFO push/full write port. up_rdy and fifo_data both come
// straight from flops, so fifo_full has no combinational path to up_rdy.
// A skid register catches the word accepted in the cycle the FIFO is full.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   up_bus     upstream data word
//   up_val     upstream valid
//   up_rdy     upstream ready (registered)
//   fifo_data  FIFO write data (output register)
//   fifo_push  FIFO write strobe, out_val & ~fifo_full
//   fifo_full  FIFO full flag, same-cycle
//   level      words held (0, 1 or 2), equal to the state encoding
module skid_fill #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] up_bus,
   input  logic                  up_val,
   output logic                  up_rdy,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_push,
   input  logic                  fifo_full,
   output logic [1:0]            level
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic                  r_up_rdy;
   logic [DATA_WIDTH-1:0] r_out;
   logic [DATA_WIDTH-1:0] r_skid;
   logic                  w_out_val;
   logic                  w_ins;
   logic                  w_push;
   logic                  w_load_out_up;
   logic                  w_load_out_skid;
   logic                  w_load_skid;

   // Handshake events for this cycle
   assign w_out_val = (r_state != EMPTY);
   assign w_ins     = up_val & r_up_rdy;
   assign w_push    = w_out_val & ~fifo_full;

   // State register and registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= EMPTY;
         r_up_rdy <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_up_rdy <= (w_state_nxt != FULL);
      end
   end

   // Next state and data-path load enables
   always_comb begin
      w_state_nxt     = r_state;
      w_load_out_up   = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_ins) begin
               w_load_out_up = 1'b1;
               w_state_nxt   = BUSY;
            end
         end
         BUSY: begin
            if (w_ins && !w_push) begin
               w_load_skid = 1'b1;
               w_state_nxt = FULL;
            end else if (w_ins && w_push) begin
               w_load_out_up = 1'b1;
            end else if (w_push) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            // up_rdy is low here, so only the drain path exists
            if (w_push) begin
               w_load_out_skid = 1'b1;
               w_state_nxt     = BUSY;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // Data registers carry no reset; validity is tracked by r_state
   always_ff @(posedge clk) begin
      if (w_load_out_up) begin
         r_out <= up_bus;
      end else if (w_load_out_skid) begin
         r_out <= r_skid;
      end
      if (w_load_skid) begin
         r_skid <= up_bus;
      end
   end

   assign up_rdy    = r_up_rdy;
   assign fifo_data = r_out;
   assign fifo_push = w_push;
   assign level     = r_state;

endmodule
